// File: rtl/ascii_encoder.sv
// ascii_encoder: streams a snapshot of the watch time as "HH:MM:SS:CC" (+CR LF) to uart_tx.
// Latency: first tx_start one cycle after send_req; each next byte one cycle after tx_done.
// Backpressure: holds in SEND while tx_busy is high; send_req is ignored while busy.
// Optional CR LF trailer enabled by defining ASCII_ENC_CRLF_EN.
module ascii_encoder #(
  parameter int MSG_LEN_BASE = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_req,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] msec,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

`ifdef ASCII_ENC_CRLF_EN
  localparam int MSG_LEN = MSG_LEN_BASE + 2;
`else
  localparam int MSG_LEN = MSG_LEN_BASE;
`endif
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [6:0]  msec_q, msec_d;
  logic        done_q, done_d;

  logic [15:0] hour_asc, min_asc, sec_asc, msec_asc;
  logic [7:0]  char_sel;

  // Two ASCII digits {tens, ones} of a value, saturated at 99.
  function automatic logic [15:0] to_ascii(input logic [6:0] v);
    logic [6:0] sat;
    logic [3:0] tens;
    logic [6:0] ones;
    sat  = (v > 7'd99) ? 7'd99 : v;
    tens = 4'd0;
    for (int t = 1; t < 10; t++) begin
      if (sat >= 7'(t * 10)) tens = 4'(t);
    end
    ones = sat - 7'({3'b000, tens} * 7'd10);
    return {8'h30 + {4'h0, tens}, 8'h30 + {4'h0, ones[3:0]}};
  endfunction

  // Digit conversion works only on the captured snapshot.
  always_comb begin
    hour_asc = to_ascii({2'b00, hour_q});
    min_asc  = to_ascii({1'b0, min_q});
    sec_asc  = to_ascii({1'b0, sec_q});
    msec_asc = to_ascii(msec_q);
  end

  // Character mux by byte index; indices past the line end read as zero.
  always_comb begin
    char_sel = 8'h00;
    case (idx_q)
      4'd0:  char_sel = hour_asc[15:8];
      4'd1:  char_sel = hour_asc[7:0];
      4'd2:  char_sel = 8'h3A;
      4'd3:  char_sel = min_asc[15:8];
      4'd4:  char_sel = min_asc[7:0];
      4'd5:  char_sel = 8'h3A;
      4'd6:  char_sel = sec_asc[15:8];
      4'd7:  char_sel = sec_asc[7:0];
      4'd8:  char_sel = 8'h3A;
      4'd9:  char_sel = msec_asc[15:8];
      4'd10: char_sel = msec_asc[7:0];
`ifdef ASCII_ENC_CRLF_EN
      4'd11: char_sel = 8'h0D;
      4'd12: char_sel = 8'h0A;
`endif
      default: char_sel = 8'h00;
    endcase
  end

  // Next-state, snapshot capture and strobe generation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    msec_d   = msec_q;
    done_d   = 1'b0;
    tx_start = 1'b0;
    busy     = (state_q != IDLE);
    tx_data  = (state_q == IDLE) ? 8'h00 : char_sel;
    case (state_q)
      IDLE: begin
        if (send_req) begin
          hour_d  = hour;
          min_d   = min;
          sec_d   = sec;
          msec_d  = msec;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A reset in this cycle aborts the line, so no strobe escapes.
        if (!tx_busy) begin
          tx_start = !rst;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and snapshot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      msec_q  <= 7'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      msec_q  <= msec_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule
